// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared CPU front-end state encodings and default vectors.
package pc_sequencer_pkg;
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
endpackage

// File: rtl/pc_sequencer_pc_block.sv
// pc_block: program counter register, async reset to RESET_VEC.
module pc_block #(
    parameter logic [31:0] RESET_VEC = pc_sequencer_pkg::DEF_RESET_VEC
) (
    input  logic        rst,
    input  logic        clk,
    input  logic [31:0] next_addr,
    output logic [31:0] curr_addr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) curr_addr <= RESET_VEC;
        else     curr_addr <= next_addr;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: BOOT/RUN/HALT fetch sequencer choosing the next PC among
// trap, halt, stall, jump, branch and sequential advance.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] curr_addr,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic        misalign,
    output logic [31:0] instr_count,
    output logic [1:0]  state
);
    state_e      state_q, state_d;
    logic [31:0] epc_q, epc_d, cnt_q, cnt_d, next_addr, tgt;
    logic        mis_q, mis_d, fv_q;

    assign pc_plus4 = curr_addr + 32'd4;
    assign tgt      = jump ? jump_target : branch_target;

    pc_block #(.RESET_VEC(RESET_VEC)) u_pc (
        .rst      (rst),
        .clk      (clk),
        .next_addr(next_addr),
        .curr_addr(curr_addr)
    );

    // Priority chain: trap beats everything; HALT only listens to trap/resume.
    always_comb begin
        state_d   = state_q;
        next_addr = curr_addr;
        epc_d     = epc_q;
        mis_d     = 1'b0;
        cnt_d     = cnt_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (trap_req) begin
            next_addr = TRAP_VEC;
            epc_d     = curr_addr;
            state_d   = RUN;
        end else if (state_q == HALT) begin
            state_d = resume ? RUN : HALT;
        end else if (halt_req) begin
            state_d = HALT;
        end else if (!stall) begin
            if ((jump || branch_taken) && tgt[1:0] != 2'b00) begin
                next_addr = TRAP_VEC;
                epc_d     = curr_addr;
                mis_d     = 1'b1;
            end else begin
                next_addr = (jump || branch_taken) ? tgt : pc_plus4;
                cnt_d     = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
            fv_q    <= (state_d == RUN);
        end
    end

    assign fetch_valid = fv_q;
    assign epc         = epc_q;
    assign misalign    = mis_q;
    assign instr_count = cnt_q;
    assign state       = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenario tasks with hand-computed expectations.
module tb_pc_sequencer;
    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, jump = 1'b0, branch_taken = 1'b0;
    logic        trap_req = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic [31:0] jump_target = '0, branch_target = '0;
    logic [31:0] curr_addr, pc_plus4, epc, instr_count;
    logic        fetch_valid, misalign;
    logic [1:0]  state;
    int total = 0, bad = 0;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .trap_req(trap_req),
        .halt_req(halt_req), .resume(resume), .curr_addr(curr_addr), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .epc(epc), .misalign(misalign),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] a);
        jump = 1'b1; jump_target = a;
        tick();
        jump = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (curr_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", curr_addr); end
        total++; if (state !== 2'd0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_state got=%0d/%b exp=0/0", state, fetch_valid); end
        total++; if (epc !== 32'h0 || misalign !== 1'b0 || instr_count !== 32'h0) begin bad++; $display("FAIL reset_regs epc=%h mis=%b cnt=%0d exp=0", epc, misalign, instr_count); end
        @(posedge clk); #1 rst = 1'b0;
        total++; if (state !== 2'd0 || fetch_valid !== 1'b0 || curr_addr !== 32'h0) begin bad++; $display("FAIL boot got st=%0d fv=%b pc=%h exp=0/0/0", state, fetch_valid, curr_addr); end
    endtask

    task automatic test_sequential();
        tick();
        total++; if (state !== 2'd1 || fetch_valid !== 1'b1 || curr_addr !== 32'h0) begin bad++; $display("FAIL run0 got st=%0d fv=%b pc=%h exp=1/1/0", state, fetch_valid, curr_addr); end
        tick();
        total++; if (curr_addr !== 32'h4) begin bad++; $display("FAIL seq4 got=%h exp=4", curr_addr); end
        tick();
        total++; if (curr_addr !== 32'h8 || instr_count !== 32'd2) begin bad++; $display("FAIL seq8 got pc=%h cnt=%0d exp=8/2", curr_addr, instr_count); end
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        total++; if (state !== 2'd2 || fetch_valid !== 1'b0 || curr_addr !== 32'h8) begin bad++; $display("FAIL halt got st=%0d fv=%b pc=%h exp=2/0/8", state, fetch_valid, curr_addr); end
        jump = 1'b1; jump_target = 32'h40; stall = 1'b1;
        tick();
        jump = 1'b0; stall = 1'b0;
        total++; if (state !== 2'd2 || curr_addr !== 32'h8) begin bad++; $display("FAIL halt_ignore got st=%0d pc=%h exp=2/8", state, curr_addr); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        total++; if (state !== 2'd1 || fetch_valid !== 1'b1 || curr_addr !== 32'h8) begin bad++; $display("FAIL resume got st=%0d fv=%b pc=%h exp=1/1/8", state, fetch_valid, curr_addr); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; trap_req = 1'b1;
        tick();
        trap_req = 1'b0;
        total++; if (state !== 2'd1 || curr_addr !== 32'h100 || epc !== 32'h8 || instr_count !== 32'd2) begin bad++; $display("FAIL halt_trap got st=%0d pc=%h epc=%h cnt=%0d exp=1/100/8/2", state, curr_addr, epc, instr_count); end
    endtask

    task automatic test_jump_priority();
        go_to(32'h10);
        jump = 1'b1; jump_target = 32'h40; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        total++; if (curr_addr !== 32'h40 || instr_count !== 32'd4) begin bad++; $display("FAIL jump_prio got pc=%h cnt=%0d exp=40/4", curr_addr, instr_count); end
        branch_taken = 1'b1; branch_target = 32'h84;
        tick();
        branch_taken = 1'b0;
        total++; if (curr_addr !== 32'h84 || instr_count !== 32'd5) begin bad++; $display("FAIL branch got pc=%h cnt=%0d exp=84/5", curr_addr, instr_count); end
    endtask

    task automatic test_stall();
        go_to(32'h20);
        stall = 1'b1; jump = 1'b1; jump_target = 32'h60;
        tick();
        jump = 1'b0;
        total++; if (curr_addr !== 32'h20 || instr_count !== 32'd6) begin bad++; $display("FAIL stall got pc=%h cnt=%0d exp=20/6", curr_addr, instr_count); end
        stall = 1'b0;
        tick();
        total++; if (curr_addr !== 32'h24 || instr_count !== 32'd7) begin bad++; $display("FAIL unstall got pc=%h cnt=%0d exp=24/7", curr_addr, instr_count); end
    endtask

    task automatic test_misalign();
        go_to(32'h30);
        branch_taken = 1'b1; branch_target = 32'h42;
        tick();
        branch_taken = 1'b0;
        total++; if (curr_addr !== 32'h100 || epc !== 32'h30 || misalign !== 1'b1 || instr_count !== 32'd8) begin bad++; $display("FAIL misalign got pc=%h epc=%h mis=%b cnt=%0d exp=100/30/1/8", curr_addr, epc, misalign, instr_count); end
        tick();
        total++; if (misalign !== 1'b0 || curr_addr !== 32'h104 || pc_plus4 !== 32'h108) begin bad++; $display("FAIL mis_pulse got mis=%b pc=%h p4=%h exp=0/104/108", misalign, curr_addr, pc_plus4); end
        trap_req = 1'b1; halt_req = 1'b1;
        tick();
        trap_req = 1'b0; halt_req = 1'b0;
        total++; if (curr_addr !== 32'h100 || epc !== 32'h104 || state !== 2'd1 || instr_count !== 32'd9) begin bad++; $display("FAIL run_trap got pc=%h epc=%h st=%0d cnt=%0d exp=100/104/1/9", curr_addr, epc, state, instr_count); end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL plus4_wrap got=%h exp=0", pc_plus4); end
        tick();
        total++; if (curr_addr !== 32'h0 || instr_count !== 32'd11) begin bad++; $display("FAIL wrap got pc=%h cnt=%0d exp=0/11", curr_addr, instr_count); end
    endtask

    task automatic test_async_reset();
        go_to(32'h50);
        stall = 1'b1;
        #3 rst = 1'b1;
        #1;
        total++; if (curr_addr !== 32'h0 || state !== 2'd0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL async_rst got pc=%h st=%0d fv=%b exp=0/0/0", curr_addr, state, fetch_valid); end
        total++; if (epc !== 32'h0 || instr_count !== 32'h0) begin bad++; $display("FAIL async_regs got epc=%h cnt=%0d exp=0/0", epc, instr_count); end
        #1 rst = 1'b0; stall = 1'b0;
        tick();
        total++; if (state !== 2'd1 || curr_addr !== 32'h0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL reboot got st=%0d pc=%h fv=%b exp=1/0/1", state, curr_addr, fetch_valid); end
        tick();
        total++; if (curr_addr !== 32'h4 || instr_count !== 32'd1) begin bad++; $display("FAIL reboot_seq got pc=%h cnt=%0d exp=4/1", curr_addr, instr_count); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_halt();
        test_jump_priority();
        test_stall();
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, address loaded into the PC on reset.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100, redirect address for traps and misaligned targets.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hold PC this cycle.
REQ-006 jump  input  1  unconditional redirect request.
REQ-007 jump_target  input  32  jump destination.
REQ-008 branch_taken  input  1  resolved-taken branch.
REQ-009 branch_target  input  32  branch destination.
REQ-010 trap_req  input  1  exception/ecall redirect request.
REQ-011 halt_req  input  1  enter HALT.
REQ-012 resume  input  1  leave HALT.
REQ-013 curr_addr  output  32  registered current PC, feeds instruction memory.
REQ-014 pc_plus4  output  32  combinational curr_addr+4, modulo 2^32.
REQ-015 fetch_valid  output  1  curr_addr is a valid fetch this cycle.
REQ-016 epc  output  32  PC captured on the last trap or misalign event.
REQ-017 misalign  output  1  one-cycle registered pulse on a misaligned redirect.
REQ-018 instr_count  output  32  count of retired (advanced) instructions.
REQ-019 state  output  2  FSM state: BOOT=0, RUN=1, HALT=2.

Function
REQ-020 BOOT shall last exactly one cycle after reset deassertion, with fetch_valid=0 and curr_addr=RESET_VEC, then go to RUN unconditionally.
REQ-021 In RUN, fetch_valid shall be 1 and the next PC shall be selected with priority trap_req > halt_req > stall > jump > branch_taken > pc_plus4.
REQ-022 trap_req in RUN or HALT shall load curr_addr=TRAP_VEC, epc=curr_addr and state=RUN on the next edge.
REQ-023 halt_req in RUN (no trap) shall hold curr_addr and enter HALT next cycle; fetch_valid=0 while in HALT.
REQ-024 In HALT, resume shall return to RUN with curr_addr unchanged; halt_req, stall, jump and branch shall be ignored.
REQ-025 stall in RUN shall hold curr_addr; the same-cycle jump and branch shall be discarded.
REQ-026 A selected jump or branch target with bits [1:0] != 0 shall load TRAP_VEC, set epc=curr_addr and pulse misalign for one cycle; it shall not count as retired.
REQ-027 Sequential advance shall wrap: 32'hFFFF_FFFC shall be followed by 32'h0000_0000.
REQ-028 instr_count shall increment by 1 on each RUN edge where curr_addr advances via pc_plus4, jump or branch with no trap and no misalign; it wraps modulo 2^32.
REQ-029 Jump and branch both asserted shall take jump_target.
REQ-030 Latency: every redirect or advance shall be visible on curr_addr exactly one edge after the request cycle.

Reset
REQ-031 rst shall act asynchronously: curr_addr=RESET_VEC, state=BOOT, fetch_valid=0, epc=0, misalign=0, instr_count=0.
REQ-032 rst asserted mid-operation, including in HALT or during a stall, shall override all requests immediately.
REQ-033 After release, the BOOT-then-RUN sequence of REQ-020 shall repeat.

Structure
REQ-034 State encodings (BOOT/RUN/HALT) and default RESET_VEC/TRAP_VEC constants shall live in a shared cpu package.
REQ-035 A single sub-module shall hold the PC register: the existing pc_block (rst, clk, next_addr, curr_addr) instantiated with next_addr driven by the selection logic.

Verification
REQ-036 Release rst, no requests -> curr_addr 0x0 for BOOT cycle (fetch_valid=0), then 0x0, 0x4, 0x8 in RUN; instr_count=2 after two advances.
REQ-037 At PC 0x10, jump=1 with jump_target=0x40 and branch_taken=1 with branch_target=0x80 -> next curr_addr=0x40.
REQ-038 At PC 0x20, stall=1 with jump_target=0x60 -> curr_addr stays 0x20; stall drop -> 0x24.
REQ-039 At PC 0x30, branch_target=0x42 -> curr_addr=0x100, epc=0x30, misalign high exactly one cycle, instr_count unchanged.
REQ-040 halt_req at PC 0x8 -> HALT, curr_addr 0x8, fetch_valid=0; jump ignored; resume -> RUN at 0x8; trap_req in HALT -> 0x100.
REQ-041 Force PC 0xFFFF_FFFC -> next 0x0; assert rst asynchronously mid-cycle -> curr_addr=0x0 and state=BOOT before the next edge.
